// File: rtl/osd_scm_ctrl.sv
// Subnet control module register back end: system info, system/CPU resets.
// Optional timed reset-pulse engine at 0x205 when OSD_SCM_CTRL_PULSE_EN is defined.
module osd_scm_ctrl #(
    parameter logic [15:0] SYSTEMID      = 16'h0,
    parameter logic [15:0] NUM_MOD       = 16'h0,
    parameter logic [15:0] MAX_PKT_LEN   = 16'h0,
    parameter int          NUM_CPU       = 1,
    parameter int          RST_PULSE_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_request,
    input  logic               reg_write,
    input  logic [15:0]        reg_addr,
    input  logic [1:0]         reg_size,
    input  logic [15:0]        reg_wdata,
    output logic               reg_ack,
    output logic               reg_err,
    output logic [15:0]        reg_rdata,
    output logic               sys_rst,
    output logic [NUM_CPU-1:0] cpu_rst
);

    logic [1:0]         sysctrl;
    logic [NUM_CPU-1:0] cpu_mask;
    logic               busy;
    logic               accept;
    logic               mapped;
    logic               ro;
    logic               err_c;
    logic               wr_en;
    logic [15:0]        rd_val;
    logic               sys_rst_next;

    // A request seen while its ack is still out is the same access.
    assign accept = reg_request & ~reg_ack;

    always_comb begin
        mapped = 1'b0;
        ro     = 1'b0;
        rd_val = 16'h0;
        case (reg_addr)
            16'h0200: begin
                mapped = 1'b1;
                ro     = 1'b1;
                rd_val = SYSTEMID;
            end
            16'h0201: begin
                mapped = 1'b1;
                ro     = 1'b1;
                rd_val = NUM_MOD;
            end
            16'h0202: begin
                mapped = 1'b1;
                ro     = 1'b1;
                rd_val = MAX_PKT_LEN;
            end
            16'h0203: begin
                mapped = 1'b1;
                rd_val = {14'b0, sysctrl};
            end
            16'h0204: begin
                mapped = 1'b1;
                rd_val = 16'(cpu_mask);
            end
`ifdef OSD_SCM_CTRL_PULSE_EN
            16'h0205: begin
                mapped = 1'b1;
                rd_val = {15'b0, busy};
            end
`endif
            default: begin
                mapped = 1'b0;
            end
        endcase
    end

    assign err_c = ~mapped | (reg_size != 2'd1) | (reg_write & ro);
    assign wr_en = accept & reg_write & ~err_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_ack   <= 1'b0;
            reg_err   <= 1'b0;
            reg_rdata <= 16'h0;
            sysctrl   <= 2'b0;
            cpu_mask  <= '1;
        end else begin
            reg_ack   <= accept;
            reg_err   <= accept & err_c;
            reg_rdata <= (accept & ~err_c & ~reg_write) ? rd_val : 16'h0;
            if (wr_en && reg_addr == 16'h0203)
                sysctrl <= reg_wdata[1:0];
            if (wr_en && reg_addr == 16'h0204)
                cpu_mask <= reg_wdata[NUM_CPU-1:0];
        end
    end

`ifdef OSD_SCM_CTRL_PULSE_EN
    localparam int CW = $clog2(RST_PULSE_LEN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RST_PULSE_LEN - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          pulse_go;

    assign pulse_go = wr_en & (reg_addr == 16'h0205) & reg_wdata[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A trigger while active reloads, so the pulse is extended.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (pulse_go) begin
                    state_next = ACTIVE;
                    cnt_next   = CNT_LOAD;
                end
            end
            ACTIVE: begin
                if (pulse_go)
                    cnt_next = CNT_LOAD;
                else if (cnt != '0)
                    cnt_next = cnt - CW'(1);
                else
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == ACTIVE);
`else
    assign busy = 1'b0;
`endif

    assign sys_rst_next = sysctrl[0] | busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sys_rst <= 1'b0;
            cpu_rst <= '0;
        end else begin
            sys_rst <= sys_rst_next;
            cpu_rst <= {NUM_CPU{sys_rst_next}} | (cpu_mask & {NUM_CPU{sysctrl[1]}});
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^reg_wdata;

endmodule

// File: tb/tb_osd_scm_ctrl.sv
// Directed bench for osd_scm_ctrl with NUM_CPU=4, RST_PULSE_LEN=16.
// Pulse scenarios follow OSD_SCM_CTRL_PULSE_EN, as the design does.
module tb_osd_scm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_request = 1'b0;
    logic        reg_write = 1'b0;
    logic [15:0] reg_addr = 16'h0;
    logic [1:0]  reg_size = 2'd1;
    logic [15:0] reg_wdata = 16'h0;
    logic        reg_ack;
    logic        reg_err;
    logic [15:0] reg_rdata;
    logic        sys_rst;
    logic [3:0]  cpu_rst;

    int checks = 0;
    int failures = 0;
    int run = 0;
    int last_run = 0;
    int pulses = 0;

    osd_scm_ctrl #(
        .SYSTEMID(16'hABCD),
        .NUM_MOD(16'h0012),
        .MAX_PKT_LEN(16'h0008),
        .NUM_CPU(4),
        .RST_PULSE_LEN(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .reg_request(reg_request),
        .reg_write(reg_write),
        .reg_addr(reg_addr),
        .reg_size(reg_size),
        .reg_wdata(reg_wdata),
        .reg_ack(reg_ack),
        .reg_err(reg_err),
        .reg_rdata(reg_rdata),
        .sys_rst(sys_rst),
        .cpu_rst(cpu_rst)
    );

    always #5 clk = ~clk;

    // Length of each completed sys_rst high run, in cycles.
    always @(negedge clk) begin
        if (sys_rst) begin
            run++;
        end else begin
            if (run != 0) begin
                last_run = run;
                pulses++;
            end
            run = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Call just after a posedge; returns just after a posedge.
    task automatic xfer(input logic w, input logic [15:0] a, input logic [1:0] s,
                        input logic [15:0] d, output logic [15:0] rd,
                        output logic e, output logic got);
        reg_request = 1'b1;
        reg_write   = w;
        reg_addr    = a;
        reg_size    = s;
        reg_wdata   = d;
        got = 1'b0;
        rd  = 16'hxxxx;
        e   = 1'bx;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (reg_ack) begin
                got = 1'b1;
                rd  = reg_rdata;
                e   = reg_err;
            end
        end
        @(posedge clk);
        #1;
        reg_request = 1'b0;
        reg_write   = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({reg_ack, reg_err, reg_rdata, sys_rst, cpu_rst} !== 23'h0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b err=%b rdata=%h sys=%b cpu=%b want all 0",
                     reg_ack, reg_err, reg_rdata, sys_rst, cpu_rst);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_info;
        logic [15:0] rd;
        logic e, g;
        logic [15:0] exp_v[3];
        exp_v[0] = 16'hABCD;
        exp_v[1] = 16'h0012;
        exp_v[2] = 16'h0008;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 16'h0200 + 16'(i), 2'd1, 16'h0, rd, e, g);
            checks++;
            if (!g || e !== 1'b0 || rd !== exp_v[i]) begin
                failures++;
                $display("FAIL info_read_%0d got=%b err=%b rdata=%h want ack err=0 rdata=%h",
                         i, g, e, rd, exp_v[i]);
            end
        end
        xfer(1'b0, 16'h0204, 2'd1, 16'h0, rd, e, g);
        checks++;
        if (!g || e !== 1'b0 || rd !== 16'h000F) begin
            failures++;
            $display("FAIL mask_reset_val got=%b err=%b rdata=%h want 000f", g, e, rd);
        end
    endtask

    task automatic test_errors;
        logic [15:0] rd;
        logic e, g;
        logic        w_v[4];
        logic [15:0] a_v[4];
        logic [1:0]  s_v[4];
        w_v = '{1'b1, 1'b0, 1'b0, 1'b1};
        a_v = '{16'h0201, 16'h0300, 16'h0203, 16'h0203};
        s_v = '{2'd1, 2'd1, 2'd2, 2'd2};
        for (int i = 0; i < 4; i++) begin
            xfer(w_v[i], a_v[i], s_v[i], 16'h0003, rd, e, g);
            checks++;
            if (!g || e !== 1'b1 || rd !== 16'h0) begin
                failures++;
                $display("FAIL err_case_%0d got=%b err=%b rdata=%h want ack err=1 rdata=0",
                         i, g, e, rd);
            end
        end
        xfer(1'b0, 16'h0203, 2'd1, 16'h0, rd, e, g);
        checks++;
        if (!g || e !== 1'b0 || rd !== 16'h0 || sys_rst !== 1'b0 || cpu_rst !== 4'h0) begin
            failures++;
            $display("FAIL err_no_effect err=%b sysctrl=%h sys=%b cpu=%b want 0",
                     e, rd, sys_rst, cpu_rst);
        end
    endtask

    task automatic test_mask;
        logic [15:0] rd;
        logic e, g;
        xfer(1'b1, 16'h0204, 2'd1, 16'hFFF5, rd, e, g);
        xfer(1'b1, 16'h0203, 2'd1, 16'h0002, rd, e, g);
        checks++;
        if (!g || e !== 1'b0 || cpu_rst !== 4'b0101 || sys_rst !== 1'b0) begin
            failures++;
            $display("FAIL cpu_mask_rst err=%b cpu=%b sys=%b want cpu=0101 sys=0",
                     e, cpu_rst, sys_rst);
        end
        xfer(1'b0, 16'h0204, 2'd1, 16'h0, rd, e, g);
        checks++;
        if (!g || e !== 1'b0 || rd !== 16'h0005) begin
            failures++;
            $display("FAIL mask_readback rdata=%h want 0005", rd);
        end
        xfer(1'b1, 16'h0203, 2'd1, 16'hFFFD, rd, e, g);
        checks++;
        if (sys_rst !== 1'b1 || cpu_rst !== 4'hF) begin
            failures++;
            $display("FAIL sysctrl_sys_rst sys=%b cpu=%b want 1 1111", sys_rst, cpu_rst);
        end
        xfer(1'b0, 16'h0203, 2'd1, 16'h0, rd, e, g);
        checks++;
        if (rd !== 16'h0001) begin
            failures++;
            $display("FAIL sysctrl_readback rdata=%h want 0001", rd);
        end
        xfer(1'b1, 16'h0203, 2'd1, 16'h0000, rd, e, g);
        checks++;
        if (sys_rst !== 1'b0 || cpu_rst !== 4'h0) begin
            failures++;
            $display("FAIL sysctrl_clear sys=%b cpu=%b want 0 0000", sys_rst, cpu_rst);
        end
    endtask

    task automatic test_back_to_back;
        int acks;
        int pairs;
        logic prev;
        acks  = 0;
        pairs = 0;
        prev  = 1'b0;
        reg_request = 1'b1;
        reg_write   = 1'b0;
        reg_addr    = 16'h0200;
        reg_size    = 2'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (reg_ack) acks++;
            if (reg_ack && prev) pairs++;
            prev = reg_ack;
        end
        reg_request = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (acks != 3 || pairs != 0) begin
            failures++;
            $display("FAIL back_to_back acks=%0d adjacent=%0d want 3 0", acks, pairs);
        end
    endtask

`ifdef OSD_SCM_CTRL_PULSE_EN
    task automatic wait_low;
        for (int i = 0; i < 60 && sys_rst; i++) @(negedge clk);
        #1;
    endtask

    task automatic test_pulse;
        logic [15:0] rd;
        logic e, g;
        int p0;
        p0 = pulses;
        xfer(1'b1, 16'h0205, 2'd1, 16'h0001, rd, e, g);
        checks++;
        if (!g || e !== 1'b0) begin
            failures++;
            $display("FAIL pulse_write got=%b err=%b want ack err=0", g, e);
        end
        xfer(1'b0, 16'h0205, 2'd1, 16'h0, rd, e, g);
        checks++;
        if (rd !== 16'h0001 || sys_rst !== 1'b1 || cpu_rst !== 4'hF) begin
            failures++;
            $display("FAIL pulse_busy rdata=%h sys=%b cpu=%b want 0001 1 1111",
                     rd, sys_rst, cpu_rst);
        end
        wait_low();
        checks++;
        if (pulses != p0 + 1 || last_run != 16) begin
            failures++;
            $display("FAIL pulse_len pulses=%0d len=%0d want %0d 16",
                     pulses - p0, last_run, 1);
        end
        xfer(1'b0, 16'h0205, 2'd1, 16'h0, rd, e, g);
        checks++;
        if (rd !== 16'h0000 || cpu_rst !== 4'h0) begin
            failures++;
            $display("FAIL pulse_done rdata=%h cpu=%b want 0000 0000", rd, cpu_rst);
        end
        xfer(1'b1, 16'h0205, 2'd1, 16'h0000, rd, e, g);
        repeat (3) @(negedge clk);
        checks++;
        if (e !== 1'b0 || sys_rst !== 1'b0) begin
            failures++;
            $display("FAIL pulse_noop err=%b sys=%b want 0 0", e, sys_rst);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_restart;
        logic [15:0] rd;
        logic e, g;
        int p0;
        p0 = pulses;
        xfer(1'b1, 16'h0205, 2'd1, 16'h0001, rd, e, g);
        repeat (8) @(posedge clk);
        #1;
        xfer(1'b1, 16'h0205, 2'd1, 16'h0001, rd, e, g);
        checks++;
        if (!g || e !== 1'b0) begin
            failures++;
            $display("FAIL restart_write got=%b err=%b want ack err=0", g, e);
        end
        wait_low();
        checks++;
        if (pulses != p0 + 1 || last_run != 26) begin
            failures++;
            $display("FAIL restart_len pulses=%0d len=%0d want 1 26", pulses - p0, last_run);
        end
    endtask

    task automatic test_rst_mid;
        logic [15:0] rd;
        logic e, g;
        xfer(1'b1, 16'h0205, 2'd1, 16'h0001, rd, e, g);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (sys_rst !== 1'b0 || cpu_rst !== 4'h0 || reg_ack !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid sys=%b cpu=%b ack=%b want 0", sys_rst, cpu_rst, reg_ack);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        xfer(1'b0, 16'h0205, 2'd1, 16'h0, rd, e, g);
        checks++;
        if (rd !== 16'h0000 || sys_rst !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_idle busy=%h sys=%b want 0000 0", rd, sys_rst);
        end
        xfer(1'b0, 16'h0204, 2'd1, 16'h0, rd, e, g);
        checks++;
        if (rd !== 16'h000F) begin
            failures++;
            $display("FAIL rst_mid_mask rdata=%h want 000f", rd);
        end
    endtask
`else
    task automatic test_no_pulse;
        logic [15:0] rd;
        logic e, g;
        xfer(1'b1, 16'h0205, 2'd1, 16'h0001, rd, e, g);
        checks++;
        if (!g || e !== 1'b1) begin
            failures++;
            $display("FAIL no_pulse_write got=%b err=%b want ack err=1", g, e);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (sys_rst !== 1'b0 || cpu_rst !== 4'h0) begin
            failures++;
            $display("FAIL no_pulse_rst sys=%b cpu=%b want 0 0000", sys_rst, cpu_rst);
        end
        @(posedge clk);
        #1;
        xfer(1'b0, 16'h0205, 2'd1, 16'h0, rd, e, g);
        checks++;
        if (!g || e !== 1'b1 || rd !== 16'h0) begin
            failures++;
            $display("FAIL no_pulse_read err=%b rdata=%h want 1 0000", e, rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_info();
        test_errors();
        test_mask();
        test_back_to_back();
`ifdef OSD_SCM_CTRL_PULSE_EN
        test_pulse();
        test_restart();
        test_rst_mid();
`else
        test_no_pulse();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
